half_adder_resp_checker: RTL and testbench
==========================================

// Module: half_adder_resp_checker
// PURPOSE
//  Consumer end of the half_adder stimulus interface: samples each (a,b) applied to a half_adder
//  together with the DUT's (sum,cout), compares them against an internal golden model, and
//  accumulates pass/fail statistics over a run of NUM_SAMPLES vectors.
//  Synthesizable; sits beside the DUT in test harnesses and on-board self-test wrappers.
// PARAMETERS
//  NUM_SAMPLES  1000  vectors per run (>=1, < 2**CNT_W)
//  CNT_W        16    width of all counters and the captured index
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      1-cycle pulse: clear stats, begin run
//  in_valid       in   1      current a/b/sum/cout form one vector
//  in_a           in   1      DUT input a
//  in_b           in   1      DUT input b
//  in_sum         in   1      DUT output sum
//  in_cout        in   1      DUT output cout
//  busy           out  1      run in progress
//  done           out  1      run complete, stats frozen
//  pass           out  1      done && err_cnt==0
//  sample_cnt     out  CNT_W  vectors accepted this run
//  err_cnt        out  CNT_W  mismatching vectors (saturates at all-ones)
//  first_err_idx  out  CNT_W  sample_cnt value of first mismatch
//  first_err_vec  out  4      {a,b,sum,cout} of first mismatch
// BEHAVIOUR
//  - Reset: state IDLE; every output 0. rst asserted mid-run aborts; no stats retained.
//  - FSM IDLE->RUN on start; RUN->DONE when final vector accepted; DONE->RUN on start.
//  - start in IDLE/DONE: counters, first_err_* cleared, state RUN next cycle. start in RUN: ignored.
//  - Vector accepted only when state==RUN && in_valid; in_valid in IDLE/DONE ignored.
//  - Golden: exp_sum = a^b, exp_cout = a&b; mismatch if either bit differs.
//  - Per accepted vector: sample_cnt+1; on mismatch err_cnt+1 (saturating); if it is the first
//    mismatch of the run, first_err_idx <= pre-increment sample_cnt, first_err_vec <= vector.
//  - Vector with sample_cnt==NUM_SAMPLES-1 accepted -> next cycle DONE: done=1, busy=0,
//    pass=(err_cnt==0) using the final vector's result. Outputs registered, 1-cycle latency.
//  - DONE holds all stats stable until start or rst. busy=1 exactly in RUN.
//  - start and in_valid together in IDLE/DONE: start wins, vector not counted.
// CONFIGURATION
//  CHK_HALT_ON_ERR_EN defined: first mismatch ends run; next cycle DONE with pass=0,
//    sample_cnt includes the failing vector, err_cnt=1.
//  Undefined: run always consumes all NUM_SAMPLES vectors regardless of errors.
// STRUCTURE
//  half_adder_chk_pkg.vh: FSM state localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2),
//    first_err_vec bit-position constants.
//  Sub-module sat_counter (WIDTH, clr, inc, q): used for sample_cnt and err_cnt.
//  Golden model and compare inline; no instance of half_adder inside the checker.
// TESTING
//  1 rst held 3 cycles, start never pulsed -> all outputs 0, in_valid ignored.
//  2 NUM_SAMPLES=4, start, 4 valid correct vectors (00/00,01/10,10/10,11/01 as ab/sum,cout)
//    -> done=1 one cycle after 4th, pass=1, sample_cnt=4, err_cnt=0.
//  3 NUM_SAMPLES=4, 2nd vector a=1,b=1,sum=1,cout=1 -> err_cnt=1, first_err_idx=1,
//    first_err_vec=4'b1111, pass=0.
//  4 CHK_HALT_ON_ERR_EN, fault on vector 0 -> done next cycle, sample_cnt=1, later in_valid ignored.
//  5 CNT_W=2, NUM_SAMPLES=3, all faulty -> err_cnt=3; rst mid-run -> IDLE, all outputs 0.
//  6 start in DONE with in_valid=1 -> stats cleared, vector not counted, busy next cycle.
//  Bench: random in_valid gaps; golden compared every cycle; $dumpfile VCD.

Source files
------------

// File: rtl/half_adder_resp_checker_pkg.sv
// Shared definitions for the half_adder response checker.
//   state_t            : checker run state (IDLE / RUN / DONE)
//   VEC_*              : bit positions inside first_err_vec = {a, b, sum, cout}
//   ha_mismatch()      : golden half-adder compare, 1 when sum or cout is wrong
package half_adder_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_A    = 3;
  localparam int VEC_B    = 2;
  localparam int VEC_SUM  = 1;
  localparam int VEC_COUT = 0;

  function automatic logic ha_mismatch(input logic a, input logic b,
                                       input logic sum, input logic cout);
    return (sum != (a ^ b)) || (cout != (a & b));
  endfunction

endpackage

// File: rtl/half_adder_resp_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   clk  in        clock
//   rst  in        synchronous active-high reset (q -> 0)
//   clr  in        synchronous clear (q -> 0), wins over inc
//   inc  in        count one when not already saturated
//   q    out WIDTH current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/half_adder_resp_checker.sv
// half_adder_resp_checker: consumes (a,b,sum,cout) vectors observed around a
// half_adder, compares each against a ^ b / a & b and accumulates run stats.
// Optional build macro: CHK_HALT_ON_ERR_EN -- the first mismatch ends the run.
// Ports:
//   clk, rst (sync, active high)     clock / reset
//   start                            pulse: clear stats and start a run (ignored while running)
//   in_valid, in_a, in_b,            one observed vector
//   in_sum, in_cout
//   busy / done / pass               run state; pass = done with no mismatches
//   sample_cnt, err_cnt (CNT_W)      accepted vectors / mismatches (saturating)
//   first_err_idx (CNT_W)            sample index of the first mismatch
//   first_err_vec (4)                {a,b,sum,cout} of the first mismatch
module half_adder_resp_checker
  import half_adder_resp_checker_pkg::*;
#(
  parameter int NUM_SAMPLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_sum,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       first_err_vec
);

  state_t state, state_nxt;
  logic   accept, mism, clr, last, halt;

  assign accept = (state == ST_RUN) && in_valid;
  // start outside RUN clears; a start inside RUN is ignored entirely
  assign clr    = start && (state != ST_RUN);
  assign mism   = ha_mismatch(in_a, in_b, in_sum, in_cout);
  assign last   = (sample_cnt == CNT_W'(NUM_SAMPLES - 1));

`ifdef CHK_HALT_ON_ERR_EN
  assign halt = mism;
`else
  assign halt = 1'b0;
`endif

  sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept),
    .q   (sample_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept && mism),
    .q   (err_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && (last || halt)) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // err_cnt is still zero when the first mismatch of the run arrives
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (accept && mism && err_cnt == '0) begin
      first_err_idx           <= sample_cnt;
      first_err_vec[VEC_A]    <= in_a;
      first_err_vec[VEC_B]    <= in_b;
      first_err_vec[VEC_SUM]  <= in_sum;
      first_err_vec[VEC_COUT] <= in_cout;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_half_adder_resp_checker.sv
module tb_half_adder_resp_checker;

  logic clk = 0, rst = 1, start1 = 0, start2 = 0;
  logic in_valid = 0, in_a = 0, in_b = 0, in_sum = 0, in_cout = 0;

  logic        busy1, done1, pass1;
  logic [15:0] scnt1, ecnt1, fidx1;
  logic [3:0]  fvec1;
  logic        busy2, done2, pass2;
  logic [1:0]  scnt2, ecnt2, fidx2;
  logic [3:0]  fvec2;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  half_adder_resp_checker #(.NUM_SAMPLES(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
    .busy(busy1), .done(done1), .pass(pass1), .sample_cnt(scnt1),
    .err_cnt(ecnt1), .first_err_idx(fidx1), .first_err_vec(fvec1));

  half_adder_resp_checker #(.NUM_SAMPLES(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
    .busy(busy2), .done(done2), .pass(pass2), .sample_cnt(scnt2),
    .err_cnt(ecnt2), .first_err_idx(fidx2), .first_err_vec(fvec2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one valid vector for one cycle, optionally preceded by a random idle gap
  task automatic send(input logic [3:0] v, input bit gap);
    if (gap) repeat ($urandom_range(2, 0)) tick();
    {in_a, in_b, in_sum, in_cout} = v;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic pulse1();
    start1 = 1; tick(); start1 = 0;
  endtask

  initial begin
    // 1: reset held with in_valid high, no start
    in_valid = 1; {in_a, in_b, in_sum, in_cout} = 4'b1110;
    repeat (3) tick();
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_pass", pass1, 0);
    chk("rst_scnt", scnt1, 0); chk("rst_ecnt", ecnt1, 0);
    chk("rst_fidx", fidx1, 0); chk("rst_fvec", fvec1, 0);
    rst = 0;
    tick(); tick();
    chk("idle_valid_ignored", scnt1, 0);
    chk("idle_busy", busy1, 0);
    in_valid = 0;

    // 2: four correct vectors
    pulse1();
    chk("t2_busy", busy1, 1);
    send(4'b0000, 1); send(4'b0110, 1); send(4'b1010, 1);
    chk("t2_not_done_at_3", done1, 0);
    start1 = 1; tick(); start1 = 0;            // start during RUN: ignored
    chk("t2_start_in_run", scnt1, 3);
    send(4'b1101, 1);
    chk("t2_done", done1, 1); chk("t2_busy_lo", busy1, 0);
    chk("t2_pass", pass1, 1); chk("t2_scnt", scnt1, 4); chk("t2_ecnt", ecnt1, 0);
    send(4'b1110, 0);                          // DONE ignores vectors
    chk("t2_done_hold", scnt1, 4);

    // 3: second vector faulty (11 -> 1,1)
    pulse1();
    send(4'b0000, 1); send(4'b1111, 1);
`ifdef CHK_HALT_ON_ERR_EN
    chk("t3_done", done1, 1); chk("t3_scnt", scnt1, 2);
`else
    chk("t3_busy", busy1, 1);
    send(4'b1010, 1); send(4'b1101, 1);
    chk("t3_done", done1, 1); chk("t3_scnt", scnt1, 4);
`endif
    chk("t3_ecnt", ecnt1, 1); chk("t3_fidx", fidx1, 1);
    chk("t3_fvec", fvec1, 4'b1111); chk("t3_pass", pass1, 0);

    // 6: start with in_valid in DONE; the faulty vector must not count
    {in_a, in_b, in_sum, in_cout} = 4'b0011;
    in_valid = 1; start1 = 1; tick(); start1 = 0; in_valid = 0;
    chk("t6_busy", busy1, 1); chk("t6_scnt", scnt1, 0);
    chk("t6_ecnt", ecnt1, 0); chk("t6_fvec", fvec1, 0); chk("t6_fidx", fidx1, 0);

    // 4: fault on vector 0
    send(4'b0010, 1);
    chk("t4_scnt", scnt1, 1); chk("t4_ecnt", ecnt1, 1);
    chk("t4_fidx", fidx1, 0); chk("t4_fvec", fvec1, 4'b0010);
`ifdef CHK_HALT_ON_ERR_EN
    chk("t4_done", done1, 1);
    send(4'b0000, 0);
    chk("t4_later_ignored", scnt1, 1);
`else
    chk("t4_busy", busy1, 1);
    send(4'b0110, 1); send(4'b0000, 1); send(4'b1101, 1);
    chk("t4_done", done1, 1); chk("t4_scnt4", scnt1, 4); chk("t4_pass", pass1, 0);
`endif

    // 5: narrow counters, all vectors faulty
    start2 = 1; tick(); start2 = 0;
    chk("t5_busy", busy2, 1);
    send(4'b1100, 1); send(4'b1100, 1);
`ifdef CHK_HALT_ON_ERR_EN
    chk("t5_done", done2, 1); chk("t5_ecnt", ecnt2, 1); chk("t5_scnt", scnt2, 1);
`else
    chk("t5_mid", done2, 0);
    send(4'b1100, 1);
    chk("t5_done", done2, 1); chk("t5_ecnt", ecnt2, 3); chk("t5_scnt", scnt2, 3);
`endif
    chk("t5_pass", pass2, 0); chk("t5_fvec", fvec2, 4'b1100);

    // 5b: rst mid-run
    start2 = 1; tick(); start2 = 0;
    send(4'b1100, 0);
    chk("t5b_running", busy2, 1);
    rst = 1; tick(); rst = 0;
    chk("t5b_busy", busy2, 0); chk("t5b_done", done2, 0); chk("t5b_pass", pass2, 0);
    chk("t5b_scnt", scnt2, 0); chk("t5b_ecnt", ecnt2, 0);
    chk("t5b_fidx", fidx2, 0); chk("t5b_fvec", fvec2, 0);
    chk("t5b_dut1_done", done1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
